// File: rtl/uartrx_fifo_pkg.sv
// Shared constants for the UART receive path and its byte buffer.
package uartrx_fifo_pkg;
  localparam int UART_DW      = 8;
  localparam int UART_FIFO_AW = 4;

  // Buffer occupancy flags, grouped so observers can bind to one signal.
  typedef struct packed {
    logic empty;
    logic full;
    logic overrun;
  } fifo_flags_t;
endpackage

// File: rtl/uartrx_fifo_ram.sv
// Storage for the receive FIFO: synchronous write, asynchronous read.
// The combinational read port lets the head byte appear on the output without a read cycle.
module uartrx_fifo_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/uartrx_fifo.sv
// First-word-fall-through byte buffer behind uartrx, with a sticky overrun flag.
// Handshake: in_req is a one-cycle strobe with no back-pressure (a byte arriving while
// full and not popped is dropped and sets overrun); rd pops the byte on dout only when empty==0.
module uartrx_fifo
  import uartrx_fifo_pkg::*;
#(
  parameter int AW = UART_FIFO_AW,
  parameter int DW = UART_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_req,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_ovr,
  output fifo_flags_t   o_flags
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overrun;

  logic          w_pop;
  logic          w_push;
  logic          w_ovr_set;
  logic [AW:0]   w_count_nxt;

  // A full FIFO still accepts a byte when the consumer frees a slot in the same cycle.
  assign w_pop     = rd & ~r_empty;
  assign w_push    = in_req & (~r_full | w_pop);
  assign w_ovr_set = in_req & r_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH);
      // Setting outranks clearing so a drop in the clearing cycle is never lost.
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_ovr) r_overrun <= 1'b0;
    end
  end

  uartrx_fifo_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (w_push & ~rst),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (dout)
  );

  assign empty   = r_empty;
  assign full    = r_full;
  assign count   = r_count;
  assign overrun = r_overrun;
  assign o_flags = '{empty: r_empty, full: r_full, overrun: r_overrun};
endmodule

// File: tb/tb_uartrx_fifo.sv
// Directed-plus-random bench for uartrx_fifo against a queue model of the byte buffer.
module tb_uartrx_fifo;
  import uartrx_fifo_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_req = 1'b0;
  logic          rd = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [W-1:0]  dout;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overrun;
  fifo_flags_t   flags;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovr = 1'b0;

  uartrx_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_req  (in_req),
    .rd      (rd),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .clr_ovr (clr_ovr),
    .o_flags (flags)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every visible output with the queue model
  task automatic check_state(input string tag);
    chk({tag, ".count"},   32'(count),   32'(exp_q.size()));
    chk({tag, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
    chk({tag, ".full"},    32'(full),    32'(exp_q.size() == DEPTH));
    chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    if (exp_q.size() != 0) chk({tag, ".dout"}, 32'(dout), 32'(exp_q[0]));
  endtask

  // model of one clock edge, written from the buffer's rules rather than its registers
  task automatic model_edge(input logic r, input logic req, input logic [W-1:0] d,
                            input logic rdv, input logic clr);
    bit pop_ok;
    bit was_full;
    if (r) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      pop_ok   = rdv && (exp_q.size() != 0);
      was_full = (exp_q.size() == DEPTH);
      if (req && was_full && !pop_ok) exp_ovr = 1'b1;
      else if (clr)                   exp_ovr = 1'b0;
      if (pop_ok) void'(exp_q.pop_front());
      if (req && (!was_full || pop_ok)) exp_q.push_back(d);
    end
  endtask

  // driver: apply inputs for one cycle, advance model, check #1 after the edge
  task automatic step(input logic r, input logic req, input logic [W-1:0] d,
                      input logic rdv, input logic clr, input string tag);
    rst = r; in_req = req; in_data = d; rd = rdv; clr_ovr = clr;
    @(posedge clk);
    model_edge(r, req, d, rdv, clr);
    #1;
    rst = 1'b0; in_req = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [W-1:0] b;

    // 1 reset with in_req held high
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, "rst0");
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, "rst1");

    // 2 single byte through
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
    chk("single_dout", 32'(dout), 32'h0A5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "single_pop");

    // 3 fill, overrun, drain, clear
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, W'(i), 1'b0, 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "ovr_push");
    chk("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_seq", 32'(dout), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr_ovr");

    // 4 pointer wrap and push+pop while full
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, "wrap_push10");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop10");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, "wrap_push12");
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, "wrap_fill");
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "full_push_pop");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

    // 5 edge cases
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_empty");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, "refill");
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, "set_vs_clr");
    chk("set_wins", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr_again");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "to_seven");
    chk("count_seven", 32'(count), 32'd7);
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, "rst_mid");

    // randomized traffic with occasional clear and rare reset
    for (int i = 0; i < 400; i++) begin
      b = W'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), b,
           ($urandom_range(0, 2) == 0) || (i > 300 && $urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
